// File: rtl/cr_tx_fid_sched.sv
// Transmit-flow scheduler: queues ready flow IDs once each and issues one per cycle in FIFO order.
// Per-cycle order of evaluation is dequeue, then fid1 enqueue, then fid2 enqueue.
module cr_tx_fid_sched #(
    parameter int unsigned FID_W     = 8,
    parameter int unsigned NUM_FLOWS = 256,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [FID_W-1:0]           rdy_fid1,
    input  logic [FID_W-1:0]           rdy_fid2,
    input  logic                       tx_ready,
    output logic [FID_W-1:0]           tx_fid_out,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       drop_clr,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DEPTH-1:0][FID_W-1:0] fifo_q, fifo_d;
    logic [NUM_FLOWS-1:0]        inq_q, inq_d;
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [OCC_W-1:0]            occ_q, occ_d;
    logic [FID_W-1:0]            tx_fid_q, tx_fid_d;
    logic [CNT_W-1:0]            drop_q, drop_d;
    logic                        full_q, full_d;
    logic                        empty_q, empty_d;

    logic [1:0][FID_W-1:0]       offer_c;
    logic [1:0]                  drops_c;
    logic [CNT_W:0]              drop_sum_c;

    assign offer_c = {rdy_fid2, rdy_fid1};

    always_comb begin
        fifo_d     = fifo_q;
        inq_d      = inq_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        tx_fid_d   = '0;
        drops_c    = '0;
        drop_sum_c = '0;

        if (en && tx_ready && !empty_q) begin
            tx_fid_d               = fifo_q[head_q];
            inq_d[fifo_q[head_q]]  = 1'b0;
            head_d                 = head_q + PTR_W'(1);
            occ_d                  = occ_q - OCC_W'(1);
        end

        // fid2 sees fid1's bitmap update, so an identical accepted fid2 is a duplicate
        for (int i = 0; i < 2; i++) begin
            if (offer_c[i] != '0 && !inq_d[offer_c[i]]) begin
                if (occ_d < OCC_W'(DEPTH)) begin
                    fifo_d[tail_d]     = offer_c[i];
                    tail_d             = tail_d + PTR_W'(1);
                    inq_d[offer_c[i]]  = 1'b1;
                    occ_d              = occ_d + OCC_W'(1);
                end else begin
                    drops_c = drops_c + 2'd1;
                end
            end
        end

        drop_sum_c = {1'b0, drop_q} + (CNT_W+1)'(drops_c);
        if (drop_clr) begin
            drop_d = '0;
        end else if (drop_sum_c[CNT_W]) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum_c[CNT_W-1:0];
        end

        full_d  = (occ_d == OCC_W'(DEPTH));
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inq_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            occ_q    <= '0;
            tx_fid_q <= '0;
            drop_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            inq_q    <= inq_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
            tx_fid_q <= tx_fid_d;
            drop_q   <= drop_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry contents are only meaningful while tracked by the pointers
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign tx_fid_out = tx_fid_q;
    assign occupancy  = occ_q;
    assign drop_cnt   = drop_q;
    assign full       = full_q;
    assign empty      = empty_q;

endmodule

// File: tb/tb_cr_tx_fid_sched.sv
// Scoreboard bench for cr_tx_fid_sched: a queue-based flow model predicts each cycle's outputs.
module tb_cr_tx_fid_sched;

    localparam int unsigned FID_W = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [FID_W-1:0] rdy_fid1 = '0;
    logic [FID_W-1:0] rdy_fid2 = '0;
    logic             tx_ready = 1'b0;
    logic             drop_clr = 1'b0;
    logic [FID_W-1:0] tx_fid_out;
    logic [4:0]       occupancy;
    logic [CNT_W-1:0] drop_cnt;
    logic             full;
    logic             empty;

    cr_tx_fid_sched #(.FID_W(FID_W), .NUM_FLOWS(256), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy_fid1(rdy_fid1), .rdy_fid2(rdy_fid2),
        .tx_ready(tx_ready), .tx_fid_out(tx_fid_out), .occupancy(occupancy),
        .drop_cnt(drop_cnt), .drop_clr(drop_clr), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fid;
        int occ;
        int dc;
        int full;
        int empty;
    } exp_t;

    exp_t exp_q[$];
    int   mq[$];
    bit   res[256];
    int   dcnt = 0;
    int   total = 0;
    int   bad = 0;

    function automatic void chk(string name, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        foreach (res[i]) res[i] = 1'b0;
        dcnt = 0;
    endfunction

    // Flow-level view: pop the oldest flow, then offer fid1 and fid2 against the resident set
    function automatic void model_step(bit e, bit tr, int f1, int f2, bit clr);
        exp_t x;
        int   offers[2];
        int   ndrop;
        x.fid = 0;
        ndrop = 0;
        if (e && tr && mq.size() > 0) begin
            x.fid = mq.pop_front();
            res[x.fid] = 1'b0;
        end
        offers[0] = f1;
        offers[1] = f2;
        foreach (offers[i]) begin
            if (offers[i] != 0 && !res[offers[i]]) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(offers[i]);
                    res[offers[i]] = 1'b1;
                end else begin
                    ndrop++;
                end
            end
        end
        if (clr) dcnt = 0;
        else dcnt = (dcnt + ndrop > 65535) ? 65535 : dcnt + ndrop;
        x.occ   = mq.size();
        x.dc    = dcnt;
        x.full  = (mq.size() == DEPTH) ? 1 : 0;
        x.empty = (mq.size() == 0) ? 1 : 0;
        exp_q.push_back(x);
    endfunction

    task automatic cyc(bit e, bit tr, int f1, int f2, bit clr);
        @(negedge clk);
        en       = e;
        tx_ready = tr;
        rdy_fid1 = FID_W'(f1);
        rdy_fid2 = FID_W'(f2);
        drop_clr = clr;
        model_step(e, tr, f1, f2, clr);
    endtask

    // Monitor: every edge the DUT presents a new output set; compare against the oldest prediction
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("tx_fid_out", int'(tx_fid_out), x.fid);
                chk("occupancy", int'(occupancy), x.occ);
                chk("drop_cnt", int'(drop_cnt), x.dc);
                chk("full", int'(full), x.full);
                chk("empty", int'(empty), x.empty);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_tx_fid", int'(tx_fid_out), 0);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        rst = 1'b0;

        repeat (10) cyc(1, 1, 0, 0, 0);

        // 5 and 9 together, then a duplicate 5; tx held off so occupancy reaches 2
        cyc(1, 0, 5, 9, 0);
        cyc(1, 0, 5, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0);

        // Fill with en=0, then overflow with two new flows
        for (int i = 1; i <= 16; i++) cyc(0, 1, i, 0, 0);
        cyc(0, 1, 17, 18, 0);

        // Full, head=1: issue 1 and re-append it, 20 drops
        cyc(1, 1, 1, 20, 0);

        // tx_ready toggling
        for (int i = 0; i < 8; i++) cyc(1, (i % 2) == 0, 0, 0, 0);

        // Clear wins over a simultaneous drop
        cyc(0, 0, 0, 0, 0);
        while (mq.size() < DEPTH) cyc(0, 0, 100 + mq.size(), 0, 0);
        cyc(0, 0, 200, 201, 1);
        cyc(0, 0, 202, 0, 0);

        // Drain, then get 7 onto tx_fid_out and reset between edges
        while (mq.size() > 0) cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 7, 0, 0);
        cyc(1, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("pre_rst_tx_fid", int'(tx_fid_out), 7);
        rst = 1'b1;
        #1;
        chk("async_rst_tx_fid", int'(tx_fid_out), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_occ", int'(occupancy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1, 7, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);

        // Randomized traffic over a small ID range to force duplicates and drops
        for (int i = 0; i < 3000; i++) begin
            bit e, tr, clr;
            int f1, f2;
            e   = ($urandom_range(0, 9) < 8);
            tr  = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 7 : 3));
            clr = ($urandom_range(0, 199) == 0);
            f1  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            f2  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            if ($urandom_range(0, 15) == 0) f2 = f1;
            cyc(e, tr, f1, f2, clr);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
